// File: rtl/frame_double_buffer.sv
// ---------------------------------------------------------------------------
// frame_double_buffer
//   Ping-pong frame buffer between the pixel generator (writer) and the VGA
//   controller (reader). The writer fills the back buffer and commits it,
//   either by writing the last pixel or by pulsing wr_commit. The buffers
//   swap only when the reader wraps from the last pixel to pixel 0, so a
//   displayed frame never tears. With no new commit, the reader keeps
//   re-reading the current front frame.
//
// Parameters
//   PIXEL_W     bits per pixel (packed R,G,B, red in the MSBs)
//   NUM_PIXELS  pixels per frame (>= 2)
//   CNT_W       width of the wrapping swap counter
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-low reset
//   rd_en       reader requests the next pixel
//   rd_data     pixel from the front buffer, one cycle after rd_en
//   rd_valid    rd_data is valid this cycle
//   rd_sof      start of frame, high with rd_valid for pixel index 0
//   wr_en       write wr_data into the back buffer
//   wr_data     pixel to write
//   wr_commit   commit a partially written back buffer
//   wr_ready    back buffer accepts writes (no commit waiting for swap)
//   swap_count  number of completed buffer swaps, wraps
// ---------------------------------------------------------------------------
module frame_double_buffer #(
  parameter int PIXEL_W    = 24,
  parameter int NUM_PIXELS = 16,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rd_en,
  output logic [PIXEL_W-1:0] rd_data,
  output logic               rd_valid,
  output logic               rd_sof,
  input  logic               wr_en,
  input  logic [PIXEL_W-1:0] wr_data,
  input  logic               wr_commit,
  output logic               wr_ready,
  output logic [CNT_W-1:0]   swap_count
);

  localparam int ADDR_W = $clog2(NUM_PIXELS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);

  // Buffer A is front while fsel == 0; the back buffer is always the other.
  logic [PIXEL_W-1:0] mem_a [NUM_PIXELS];
  logic [PIXEL_W-1:0] mem_b [NUM_PIXELS];

  logic              fsel;
  logic              pending;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] wr_idx;

  logic rd_wrap;
  logic wr_fire;
  logic wr_last;
  logic commit;
  logic do_swap;

  assign wr_ready = ~pending;
  assign rd_wrap  = rd_en && (rd_idx == LAST_IDX);
  assign wr_fire  = wr_en && wr_ready;
  assign wr_last  = wr_fire && (wr_idx == LAST_IDX);
  assign commit   = wr_commit && wr_ready;
  // A commit landing on the wrap cycle only raises pending, so the swap
  // waits for the next wrap. A swap cycle never carries a write because
  // pending (hence !wr_ready) is what enables the swap.
  assign do_swap  = rd_wrap && pending;

  // NOTE: memories have no reset so they map onto block RAM; their contents
  // survive reset and unwritten pixels simply stay stale.
  always_ff @(posedge clk) begin
    if (reset && wr_fire) begin
      if (fsel) mem_a[wr_idx] <= wr_data;
      else      mem_b[wr_idx] <= wr_data;
    end
  end

  // Registered read port; rd_data holds its last value when rd_en is low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= fsel ? mem_b[rd_idx] : mem_a[rd_idx];
    end
  end

  // NOTE: all state here is updated with non-blocking assignments, so every
  // condition above reads this cycle's registered values (e.g. pending).
  always_ff @(posedge clk) begin
    if (!reset) begin
      fsel       <= 1'b0;
      pending    <= 1'b0;
      rd_idx     <= '0;
      wr_idx     <= '0;
      rd_valid   <= 1'b0;
      rd_sof     <= 1'b0;
      swap_count <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_sof   <= rd_en && (rd_idx == '0);

      if (rd_en) begin
        rd_idx <= rd_wrap ? '0 : rd_idx + 1'b1;
      end

      if (do_swap) begin
        fsel       <= ~fsel;
        pending    <= 1'b0;
        wr_idx     <= '0;
        swap_count <= swap_count + 1'b1;
      end else begin
        if (wr_last || commit) begin
          pending <= 1'b1;
        end
        // The index parks on the last pixel once the frame is full.
        if (wr_fire && !wr_last) begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_double_buffer.sv
// ---------------------------------------------------------------------------
// tb_frame_double_buffer
//   Self-checking bench for frame_double_buffer. A behavioural model of the
//   two frames pushes the expected pixel onto a scoreboard whenever a read
//   is issued; the entry is popped and compared when rd_valid appears.
//   Control outputs are compared against the model every cycle.
// ---------------------------------------------------------------------------
module tb_frame_double_buffer;

  localparam int PW = 24;
  localparam int NP = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rd_en = 1'b0;
  logic [PW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_sof;
  logic          wr_en = 1'b0;
  logic [PW-1:0] wr_data = '0;
  logic          wr_commit = 1'b0;
  logic          wr_ready;
  logic [CW-1:0] swap_count;

  frame_double_buffer #(.PIXEL_W(PW), .NUM_PIXELS(NP), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_sof     (rd_sof),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_commit  (wr_commit),
    .wr_ready   (wr_ready),
    .swap_count (swap_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: index 0 = frame A, 1 = frame B.
  typedef struct {
    logic [PW-1:0] data;
    bit            sof;
    bit            known;
  } exp_t;

  exp_t          sb[$];
  logic [PW-1:0] m_mem   [2][NP];
  bit            m_known [2][NP];
  bit            m_fsel;
  bit            m_pending;
  int            m_rd_idx;
  int            m_wr_idx;
  logic [CW-1:0] m_swap;
  bit            m_valid;
  logic [PW-1:0] m_last_data;
  bit            m_last_known;

  task automatic model_step();
    exp_t e;
    bit   boundary;
    bit   np;
    int   back;
    boundary = rd_en && (m_rd_idx == NP - 1);
    np       = m_pending;
    back     = m_fsel ? 0 : 1;
    m_valid  = rd_en;
    if (rd_en) begin
      e.data  = m_mem[m_fsel][m_rd_idx];
      e.known = m_known[m_fsel][m_rd_idx];
      e.sof   = (m_rd_idx == 0);
      sb.push_back(e);
      m_rd_idx = boundary ? 0 : m_rd_idx + 1;
    end
    if (wr_en && !m_pending) begin
      m_mem[back][m_wr_idx]   = wr_data;
      m_known[back][m_wr_idx] = 1'b1;
      if (m_wr_idx == NP - 1) np = 1'b1;
      else                    m_wr_idx++;
    end
    if (wr_commit && !m_pending) np = 1'b1;
    if (boundary && m_pending) begin
      m_fsel   = ~m_fsel;
      np       = 1'b0;
      m_wr_idx = 0;
      m_swap   = m_swap + 1'b1;
    end
    m_pending = np;
  endtask

  task automatic model_reset();
    m_fsel       = 1'b0;
    m_pending    = 1'b0;
    m_rd_idx     = 0;
    m_wr_idx     = 0;
    m_swap       = '0;
    m_valid      = 1'b0;
    m_last_data  = '0;
    m_last_known = 1'b1;
    sb.delete();
  endtask

  // One clock: update the model at the edge, compare 1 time unit later.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    if (!reset) model_reset();
    else        model_step();
    #1;
    check("rd_valid", rd_valid, m_valid);
    if (rd_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rd_valid", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        check("rd_sof", rd_sof, e.sof);
        if (e.known) check("rd_data", rd_data, e.data);
        m_last_data  = e.data;
        m_last_known = e.known;
      end
    end else begin
      if (m_valid && sb.size() > 0) void'(sb.pop_front());
      check("rd_sof_idle", rd_sof, 1'b0);
      if (m_last_known) check("rd_data_hold", rd_data, m_last_data);
    end
    check("wr_ready", wr_ready, !m_pending);
    check("swap_count", swap_count, m_swap);
  endtask

  task automatic drive(input bit r, input bit w, input logic [PW-1:0] d, input bit c);
    rd_en     = r;
    wr_en     = w;
    wr_data   = d;
    wr_commit = c;
    tick();
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NP; i++) begin
        m_mem[b][i]   = '0;
        m_known[b][i] = 1'b0;
      end
    model_reset();

    // Reset and its output state.
    reset = 1'b0;
    drive(0, 0, '0, 0);
    drive(0, 0, '0, 0);
    check("reset_rd_valid", rd_valid, 1'b0);
    check("reset_rd_data", rd_data, 24'h0);
    check("reset_wr_ready", wr_ready, 1'b1);
    reset = 1'b1;
    drive(0, 0, '0, 0);

    // One frame of reads, with an idle gap, no writes: no swap.
    for (int i = 0; i < NP; i++) begin
      drive(1, 0, '0, 0);
      if (i == 5) drive(0, 0, '0, 0);
    end
    drive(0, 0, '0, 0);
    check("no_write_swap_count", swap_count, 8'd0);

    // Fill the back buffer with red; the 16th write auto-commits.
    for (int i = 0; i < NP; i++) drive(0, 1, 24'hFF0000, 0);
    check("after_fill_wr_ready", wr_ready, 1'b0);

    // Read a frame while writes (and a commit) are dropped; swap at the wrap.
    for (int i = 0; i < NP; i++) drive(1, 1, 24'h0000FF, (i == 3));
    check("first_swap_count", swap_count, 8'd1);
    for (int i = 0; i < NP; i++) begin
      drive(1, 0, '0, 0);
      check("red_frame", rd_data, 24'hFF0000);
    end

    // Partial frame: 4 blue pixels, the last together with wr_commit.
    for (int i = 0; i < 3; i++) drive(0, 1, 24'h0000FF, 0);
    drive(0, 1, 24'h0000FF, 1);
    check("partial_commit_wr_ready", wr_ready, 1'b0);
    for (int i = 0; i < NP; i++) drive(1, 0, '0, 0);
    check("second_swap_count", swap_count, 8'd2);
    for (int i = 0; i < NP; i++) begin
      drive(1, 0, '0, 0);
      if (i < 4) check("blue_pixel", rd_data, 24'h0000FF);
    end

    // Auto-commit lands on the read wrap: swap is deferred by one frame.
    for (int i = 0; i < NP; i++) drive(1, 1, 24'h001000 + PW'(i), 0);
    check("deferred_no_swap", swap_count, 8'd2);
    check("deferred_pending", wr_ready, 1'b0);
    for (int i = 0; i < NP; i++) drive(1, 0, '0, 0);
    check("deferred_swap", swap_count, 8'd3);

    // No commits for 3 frames: the same frame repeats.
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < NP; i++) begin
        drive(1, 0, '0, 0);
        check("repeat_frame", rd_data, 24'h001000 + PW'(i));
      end
    check("repeat_swap_count", swap_count, 8'd3);

    // Reset mid-frame: 7 writes into back buffer A, 9 reads of front B.
    for (int i = 0; i < 9; i++) drive(1, (i < 7), 24'hABC000 + PW'(i), 0);
    reset = 1'b0;
    drive(0, 0, '0, 0);
    check("midreset_rd_valid", rd_valid, 1'b0);
    check("midreset_wr_ready", wr_ready, 1'b1);
    check("midreset_swap_count", swap_count, 8'd0);
    reset = 1'b1;
    drive(1, 0, '0, 0);
    check("post_reset_a0", rd_data, 24'hABC000);
    check("post_reset_sof", rd_sof, 1'b1);

    // Randomised mix of reads, writes and commits against the model.
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            PW'($urandom), $urandom_range(0, 15) == 0);
    drive(0, 0, '0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_double_buffer.md
Name: frame_double_buffer

Overview:
Parametrised ping-pong frame buffer between the pixel generator (writer) and the VGA controller (reader). This is the successor to the fixed 16-pixel, 24-bit double buffer:
- Pixel width and frame depth are parameters.
- The writer explicitly commits a frame, with back-pressure while a committed frame awaits display.
- Buffers swap only at a read-frame boundary, so output never tears.
- The reader repeats the current front frame when no new frame is committed.

Parameters:
PIXEL_W, 24, bits per pixel (packed R,G,B, MSB = red)
NUM_PIXELS, 16, pixels per frame (>= 2)
ADDR_W, $clog2(NUM_PIXELS), index width (derived; not overridden)
CNT_W, 8, width of the swap counter

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
rd_en  in  1  reader requests next pixel
rd_data  out  PIXEL_W  pixel from front buffer
rd_valid  out  1  rd_data valid this cycle
rd_sof  out  1  start of frame; high with rd_valid on pixel index 0
wr_en  in  1  write wr_data into back buffer
wr_data  in  PIXEL_W  pixel to write
wr_commit  in  1  commit back buffer early (partial frame)
wr_ready  out  1  back buffer accepts writes
swap_count  out  CNT_W  number of completed buffer swaps, wraps

Behaviour:
- State:
  - fsel: 0 means A is front, B is back.
  - rd_idx, wr_idx: ADDR_W bits each.
  - pending: a committed frame is waiting for swap.
- Reset (reset==0 at posedge):
  - rd_data=0, rd_valid=0, rd_sof=0, swap_count=0.
  - fsel=0, rd_idx=0, wr_idx=0, pending=0.
  - wr_ready=1.
  - Memory contents are not cleared.
  - Reset mid-frame abandons both the read and write frames.
- wr_ready = ~pending (combinational from a register).
- Read, 1-cycle latency:
  - On a cycle with rd_en=1, the next cycle drives rd_valid=1 and rd_data=front[rd_idx].
  - rd_sof=1 when the rd_idx used was 0.
  - With rd_en=0, the next cycle has rd_valid=0 and rd_sof=0; rd_data holds its last value.
- Read index:
  - rd_idx increments on each rd_en.
  - When rd_idx==NUM_PIXELS-1 with rd_en, rd_idx wraps to 0. This is the frame boundary.
- Swap, at the frame boundary:
  - If pending==1 (registered value): toggle fsel, clear pending, wr_idx<=0, swap_count<=swap_count+1. The next rd_en reads the new front from index 0.
  - If pending==0: no swap; the same front frame is re-read (repeat).
- Write:
  - When wr_en && wr_ready: back[wr_idx] <= wr_data, and wr_idx increments.
  - Writing index NUM_PIXELS-1 sets pending=1 (auto-commit); wr_idx stays at NUM_PIXELS-1.
  - When wr_en && !wr_ready: the write is ignored (dropped, no error).
- Explicit commit:
  - wr_commit && wr_ready sets pending=1.
  - Unwritten back-buffer pixels keep their stale contents.
  - wr_commit while pending is ignored.
  - A wr_en in the same cycle as wr_commit is written first, then committed.
- Simultaneous events:
  - A commit (auto or explicit) in the same cycle as a read frame boundary does not swap at that boundary. Pending becomes 1 and the swap happens at the next boundary.
  - Reads and writes never address the same buffer, so there is no same-address hazard.
- fsel and the back-buffer select both change only on the swap edge. A write in the swap cycle is blocked because wr_ready=0.
- Memory: two NUM_PIXELS x PIXEL_W arrays with a synchronous read, inferable as block RAM.
- swap_count wraps modulo 2^CNT_W.

Test Plan:
- Reset, then 16 rd_en pulses with no writes -> rd_valid follows rd_en by 1 cycle; rd_sof high only on the first; swap_count=0; wr_ready=1.
- Write 16 pixels 24'hFF0000 -> wr_ready drops after the 16th write. Then read 16 pixels -> no swap until the read wrap, after which swap_count=1. The next 16 reads all return 24'hFF0000, with rd_sof on the first.
- After the commit above, drive wr_en with 24'h0000FF before the swap -> writes are dropped. After the swap, write 4 pixels of 24'h0000FF and pulse wr_commit. At the next boundary: swap_count=2, pixels 0-3 = 24'h0000FF, pixels 4-15 hold their stale back-buffer values.
- Auto-commit on the same cycle as the rd_idx 15->0 wrap -> no swap at that wrap; the swap occurs one frame later and swap_count increments exactly once.
- No commit for 3 read frames -> the front frame repeats identically 3 times; swap_count unchanged.
- Assert reset mid-write (wr_idx=7) and mid-read (rd_idx=9) -> next cycle rd_valid=0, wr_ready=1, swap_count=0; the first subsequent read returns A[0] with rd_sof=1.
